linebuf_sched: RTL and testbench

- VCLK-domain sequencer for the 4-page line-doubler video buffer.
- Owns write-page and read-page pointers and the page fill level.
- Primes the buffer on a frame start, then issues each read page RD_REPEAT times.
- Flags overrun and underrun, and falls back to passthrough (run=0) on any fault.

---
 rtl/linebuf_sched_pkg.sv | 31 +++
 rtl/linebuf_len_regs.sv | 36 +++
 rtl/linebuf_sched.sv | 209 ++++++++++++++++++++
 tb/tb_linebuf_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : linebuf_sched_pkg
// Brief    : Shared video parameters and state encoding for the line doubler.
// Revision : 1.0 - initial release
// ============================================================================
package linebuf_sched_pkg;

  // Four pages cover NTSC/PAL at 2x pixels per line (max 1600 VCLK cycles).
  localparam int c_NUM_PAGES = 4;
  localparam int c_LINE_MIN  = 640;
  localparam int c_LINE_MAX  = 1600;

  localparam logic [1:0] c_ST_IDLE       = 2'd0;
  localparam logic [1:0] c_ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] c_ST_PRIME      = 2'd2;
  localparam logic [1:0] c_ST_RUN        = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = c_ST_IDLE,
    ST_WAIT_FRAME = c_ST_WAIT_FRAME,
    ST_PRIME      = c_ST_PRIME,
    ST_RUN        = c_ST_RUN
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/linebuf_len_regs.sv
`default_nettype none
// ============================================================================
// Module   : linebuf_len_regs
// Brief    : Per-page stored line length; one write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
module linebuf_len_regs #(
  parameter int NUM_PAGES = 4,
  parameter int PAGE_W    = 2,
  parameter int LINE_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [PAGE_W-1:0] i_wr_page,
  input  logic [LINE_W-1:0] i_wr_len,
  input  logic [PAGE_W-1:0] i_rd_page,
  output logic [LINE_W-1:0] o_rd_len
);

  logic [LINE_W-1:0] r_len [NUM_PAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PAGES; i++) begin
        r_len[i] <= '0;
      end
    end else if (i_we) begin
      r_len[i_wr_page] <= i_wr_len;
    end
  end

  assign o_rd_len = r_len[i_rd_page];

endmodule
`default_nettype wire

// File: rtl/linebuf_sched.sv
`default_nettype none
// ============================================================================
// Module   : linebuf_sched
// Brief    : VCLK-domain page sequencer for the line-doubler buffer.
// Revision : 1.0 - initial release
// ============================================================================
module linebuf_sched
  import linebuf_sched_pkg::*;
#(
  parameter int NUM_PAGES   = c_NUM_PAGES,
  parameter int PRIME_LINES = 2,
  parameter int RD_REPEAT   = 2,
  parameter int LINE_W      = 11,
  parameter int LINE_MIN    = c_LINE_MIN,
  parameter int LINE_MAX    = c_LINE_MAX,
  localparam int PAGE_W     = clog2_min1(NUM_PAGES),
  localparam int PASS_W     = clog2_min1(RD_REPEAT),
  localparam int FILL_W     = $clog2(NUM_PAGES + 1)
) (
  input  logic              VCLK,
  input  logic              nRST,
  input  logic              enable,
  input  logic              new_frame,
  input  logic              odd_field,
  input  logic              interlaced,
  input  logic              wr_line_end,
  input  logic [LINE_W-1:0] wr_line_len,
  input  logic              rd_line_end,
  output logic [PAGE_W-1:0] wrpage,
  output logic [PAGE_W-1:0] rdpage,
  output logic [PASS_W-1:0] rd_pass,
  output logic [LINE_W-1:0] rd_line_len,
  output logic              run,
  output logic              frame_start,
  output logic              overrun,
  output logic              underrun
);

  state_t            r_state, w_state_nxt;
  logic [PAGE_W-1:0] r_wrptr, w_wrptr_nxt;
  logic [PAGE_W-1:0] r_rdptr, w_rdptr_nxt;
  logic [PAGE_W-1:0] r_rdpage, w_rdpage_nxt;
  logic [FILL_W-1:0] r_fill, w_fill_nxt;
  logic [PASS_W-1:0] r_pass, w_pass_nxt;
  logic              r_odd, w_odd_nxt;
  logic              r_fs_pend, w_fs_pend_nxt;
  logic              r_run, w_run_nxt;
  logic              r_fs, w_fs_nxt;
  logic              r_ovr, w_ovr_nxt;
  logic              r_udr, w_udr_nxt;
  logic              w_len_ok, w_consume, w_advance, w_len_we;

  assign w_len_ok  = (wr_line_len >= LINE_W'(LINE_MIN)) && (wr_line_len < LINE_W'(LINE_MAX));
  assign w_consume = rd_line_end && (r_pass == PASS_W'(RD_REPEAT - 1));
  assign w_len_we  = enable && wr_line_end && ((r_state == ST_PRIME) || (r_state == ST_RUN));

  always_comb begin
    w_state_nxt   = r_state;
    w_wrptr_nxt   = r_wrptr;
    w_rdptr_nxt   = r_rdptr;
    w_fill_nxt    = r_fill;
    w_pass_nxt    = r_pass;
    w_odd_nxt     = r_odd;
    w_fs_pend_nxt = r_fs_pend;
    w_ovr_nxt     = r_ovr;
    w_udr_nxt     = r_udr;
    w_advance     = 1'b0;

    if (!enable) begin
      w_state_nxt   = ST_IDLE;
      w_wrptr_nxt   = '0;
      w_rdptr_nxt   = '0;
      w_fill_nxt    = '0;
      w_pass_nxt    = '0;
      w_fs_pend_nxt = 1'b0;
    end else begin
      if (new_frame) begin
        w_ovr_nxt = 1'b0;
        w_udr_nxt = 1'b0;
      end
      case (r_state)
        ST_IDLE: w_state_nxt = ST_WAIT_FRAME;
        ST_WAIT_FRAME, ST_PRIME: begin
          if (new_frame) begin
            w_state_nxt   = ST_PRIME;
            w_wrptr_nxt   = '0;
            w_rdptr_nxt   = '0;
            w_fill_nxt    = '0;
            w_pass_nxt    = '0;
            w_fs_pend_nxt = 1'b0;
            w_odd_nxt     = odd_field;
          end else if ((r_state == ST_PRIME) && wr_line_end) begin
            if (!w_len_ok) begin
              w_state_nxt = ST_WAIT_FRAME;
            end else begin
              w_wrptr_nxt = r_wrptr + PAGE_W'(1);
              w_fill_nxt  = r_fill + FILL_W'(1);
              if ((r_fill + FILL_W'(1)) == FILL_W'(PRIME_LINES)) begin
                w_state_nxt = ST_RUN;
                w_pass_nxt  = '0;
              end
            end
          end
        end
        ST_RUN: begin
          if (wr_line_end && !w_len_ok) begin
            w_state_nxt = ST_WAIT_FRAME;
          end else if (wr_line_end && (r_fill == FILL_W'(NUM_PAGES)) && !w_consume) begin
            w_state_nxt = ST_WAIT_FRAME;
            w_ovr_nxt   = 1'b1;
          end else if (w_consume && (r_fill == '0)) begin
            w_state_nxt = ST_WAIT_FRAME;
            w_udr_nxt   = 1'b1;
          end else begin
            if (wr_line_end) begin
              w_wrptr_nxt = r_wrptr + PAGE_W'(1);
            end
            if (w_consume) begin
              w_pass_nxt  = '0;
              w_rdptr_nxt = r_rdptr + PAGE_W'(1);
              w_advance   = 1'b1;
            end else if (rd_line_end) begin
              w_pass_nxt = r_pass + PASS_W'(1);
            end
            if (wr_line_end && !w_consume) begin
              w_fill_nxt = r_fill + FILL_W'(1);
            end else if (!wr_line_end && w_consume) begin
              w_fill_nxt = r_fill - FILL_W'(1);
            end
          end
          // A frame boundary seen mid-run marks the next page advance as frame start.
          if (w_advance) begin
            w_fs_pend_nxt = 1'b0;
          end
          if (new_frame) begin
            w_odd_nxt     = odd_field;
            w_fs_pend_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Even fields of interlaced video fetch the previous page on the first pass.
  always_comb begin
    w_rdpage_nxt = w_rdptr_nxt;
    if ((w_state_nxt == ST_RUN) && interlaced && !w_odd_nxt && (w_pass_nxt == '0)) begin
      w_rdpage_nxt = w_rdptr_nxt - PAGE_W'(1);
    end
  end

  assign w_run_nxt = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_fs_nxt  = w_run_nxt && (!r_run || (r_fs_pend && w_advance));

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      r_wrptr   <= '0;
      r_rdptr   <= '0;
      r_rdpage  <= '0;
      r_fill    <= '0;
      r_pass    <= '0;
      r_odd     <= 1'b0;
      r_fs_pend <= 1'b0;
      r_run     <= 1'b0;
      r_fs      <= 1'b0;
      r_ovr     <= 1'b0;
      r_udr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wrptr   <= w_wrptr_nxt;
      r_rdptr   <= w_rdptr_nxt;
      r_rdpage  <= w_rdpage_nxt;
      r_fill    <= w_fill_nxt;
      r_pass    <= w_pass_nxt;
      r_odd     <= w_odd_nxt;
      r_fs_pend <= w_fs_pend_nxt;
      r_run     <= w_run_nxt;
      r_fs      <= w_fs_nxt;
      r_ovr     <= w_ovr_nxt;
      r_udr     <= w_udr_nxt;
    end
  end

  linebuf_len_regs #(
    .NUM_PAGES (NUM_PAGES),
    .PAGE_W    (PAGE_W),
    .LINE_W    (LINE_W)
  ) u_len_regs (
    .clk       (VCLK),
    .rst_n     (nRST),
    .i_we      (w_len_we),
    .i_wr_page (r_wrptr),
    .i_wr_len  (wr_line_len),
    .i_rd_page (r_rdpage),
    .o_rd_len  (rd_line_len)
  );

  assign wrpage      = r_wrptr;
  assign rdpage      = r_rdpage;
  assign rd_pass     = r_pass;
  assign run         = r_run;
  assign frame_start = r_fs;
  assign overrun     = r_ovr;
  assign underrun    = r_udr;

endmodule
`default_nettype wire

// File: tb/tb_linebuf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_linebuf_sched
// Brief    : Scoreboard bench for linebuf_sched with directed stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_linebuf_sched;

  localparam int LINE_W = 11;

  logic              VCLK;
  logic              nRST;
  logic              enable;
  logic              new_frame;
  logic              odd_field;
  logic              interlaced;
  logic              wr_line_end;
  logic [LINE_W-1:0] wr_line_len;
  logic              rd_line_end;
  logic [1:0]        wrpage;
  logic [1:0]        rdpage;
  logic [0:0]        rd_pass;
  logic [LINE_W-1:0] rd_line_len;
  logic              run;
  logic              frame_start;
  logic              overrun;
  logic              underrun;

  linebuf_sched dut (
    .VCLK        (VCLK),
    .nRST        (nRST),
    .enable      (enable),
    .new_frame   (new_frame),
    .odd_field   (odd_field),
    .interlaced  (interlaced),
    .wr_line_end (wr_line_end),
    .wr_line_len (wr_line_len),
    .rd_line_end (rd_line_end),
    .wrpage      (wrpage),
    .rdpage      (rdpage),
    .rd_pass     (rd_pass),
    .rd_line_len (rd_line_len),
    .run         (run),
    .frame_start (frame_start),
    .overrun     (overrun),
    .underrun    (underrun)
  );

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  // Expected output snapshot; a field of -1 is not compared.
  typedef struct {
    int    at;
    string name;
    int    wp, rp, ps, rn, fs, ov, ud, ln;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge VCLK) cyc++;

  function automatic bit m(input int e, input int a);
    return (e < 0) || (e == a);
  endfunction

  task automatic check(input exp_t e);
    bit ok;
    ok = m(e.wp, int'(wrpage)) && m(e.rp, int'(rdpage)) && m(e.ps, int'(rd_pass)) &&
         m(e.rn, int'(run)) && m(e.fs, int'(frame_start)) && m(e.ov, int'(overrun)) &&
         m(e.ud, int'(underrun)) && m(e.ln, int'(rd_line_len));
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got wp=%0d rp=%0d pass=%0d run=%0d fs=%0d ovr=%0d udr=%0d len=%0d, expected wp=%0d rp=%0d pass=%0d run=%0d fs=%0d ovr=%0d udr=%0d len=%0d",
                  e.name, wrpage, rdpage, rd_pass, run, frame_start, overrun, underrun, rd_line_len,
                  e.wp, e.rp, e.ps, e.rn, e.fs, e.ov, e.ud, e.ln);
  endtask

  always @(negedge VCLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      if (e.at < cyc) begin
        n_chk++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.at);
      end else begin
        check(e);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input string nm, input bit we, input int len, input bit re, input bit nf,
                      input int wp, input int rp, input int ps, input int rn,
                      input int fs, input int ov, input int ud, input int ln);
    exp_t e;
    e.at = cyc + 1; e.name = nm;
    e.wp = wp; e.rp = rp; e.ps = ps; e.rn = rn; e.fs = fs; e.ov = ov; e.ud = ud; e.ln = ln;
    q.push_back(e);
    wr_line_end = we;
    wr_line_len = LINE_W'(len);
    rd_line_end = re;
    new_frame   = nf;
    @(posedge VCLK); #1;
    wr_line_end = 1'b0;
    rd_line_end = 1'b0;
    new_frame   = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    exp_t e;
    e.at = cyc; e.name = nm;
    e.wp = 0; e.rp = 0; e.ps = 0; e.rn = 0; e.fs = 0; e.ov = 0; e.ud = 0; e.ln = 0;
    check(e);
  endtask

  initial begin
    nRST = 1'b0; enable = 1'b0; new_frame = 1'b0; odd_field = 1'b0; interlaced = 1'b0;
    wr_line_end = 1'b0; wr_line_len = '0; rd_line_end = 1'b0;
    repeat (3) @(posedge VCLK);
    #1;
    check_zero("rst_hold");
    nRST = 1'b1;
    //   name        we len  re nf   wp rp ps rn fs ov ud len
    step("rst_idle", 0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 0);

    enable = 1'b1;
    step("a_en",     0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    step("a_nf",     0, 0,    0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    step("a_wr1",    1, 1560, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1560);
    step("a_wr2",    1, 1560, 0, 0,  2, 0, 0, 0, 0, 0, 0, 1560);
    step("a_run",    0, 0,    0, 0,  2, 0, 0, 1, 1, 0, 0, 1560);
    step("a_fs1",    0, 0,    0, 0,  2, 0, 0, 1, 0, 0, 0, 1560);

    step("b1",       0, 0,    1, 0,  2, 0, 1, 1, 0, 0, 0, 1560);
    step("b2",       1, 700,  1, 0,  3, 1, 0, 1, 0, 0, 0, 1560);
    step("b3",       0, 0,    1, 0,  3, 1, 1, 1, 0, 0, 0, 1560);
    step("b4",       1, 800,  1, 0,  0, 2, 0, 1, 0, 0, 0, 700);
    step("b5",       0, 0,    1, 0,  0, 2, 1, 1, 0, 0, 0, 700);
    step("b6",       1, 900,  1, 0,  1, 3, 0, 1, 0, 0, 0, 800);
    step("b7",       0, 0,    1, 0,  1, 3, 1, 1, 0, 0, 0, 800);
    step("b8",       1, 1000, 1, 0,  2, 0, 0, 1, 0, 0, 0, 900);

    step("c1",       1, 1000, 0, 0,  3, 0, 0, 1, 0, 0, 0, 900);
    step("c2",       1, 1100, 0, 0,  0, 0, 0, 1, 0, 0, 0, 900);
    step("c_ovr",    1, 1200, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1200);
    step("c_sticky", 0, 0,    0, 0,  0, 0, 0, 0, 0, 1, 0, 1200);
    step("c_clr",    0, 0,    0, 1,  0, 0, 0, 0, 0, 0, 0, 1200);

    step("d1",       1, 1500, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1500);
    step("d2",       1, 1500, 0, 0,  2, 0, 0, 0, 0, 0, 0, 1500);
    step("d_run",    0, 0,    0, 0,  2, 0, 0, 1, 1, 0, 0, 1500);
    step("d4",       0, 0,    1, 0,  2, 0, 1, 1, 0, 0, 0, 1500);
    step("d5",       0, 0,    1, 0,  2, 1, 0, 1, 0, 0, 0, 1500);
    step("d6",       0, 0,    1, 0,  2, 1, 1, 1, 0, 0, 0, 1500);
    step("d7",       0, 0,    1, 0,  2, 2, 0, 1, 0, 0, 0, 1000);
    step("d8",       0, 0,    1, 0,  2, 2, 1, 1, 0, 0, 0, 1000);
    step("d_udr",    0, 0,    1, 0,  2, 2, 1, 0, 0, 0, 1, 1000);
    step("d_sticky", 0, 0,    0, 0,  2, 2, 1, 0, 0, 0, 1, 1000);

    interlaced = 1'b1; odd_field = 1'b0;
    step("e_nf",     0, 0,    0, 1,  0, 0, 0, 0, 0, 0, 0, 1500);
    step("e_wr1",    1, 700,  0, 0,  1, 0, 0, 0, 0, 0, 0, 700);
    step("e_wr2",    1, 750,  0, 0,  2, 3, 0, 0, 0, 0, 0, 1100);
    step("e_run",    0, 0,    0, 0,  2, 3, 0, 1, 1, 0, 0, 1100);
    step("e5",       0, 0,    1, 0,  2, 0, 1, 1, 0, 0, 0, 700);
    step("e6",       1, 800,  1, 0,  3, 0, 0, 1, 0, 0, 0, 700);
    step("e7",       0, 0,    1, 0,  3, 1, 1, 1, 0, 0, 0, 750);
    step("e8",       1, 850,  1, 0,  0, 1, 0, 1, 0, 0, 0, 750);
    step("e9",       0, 0,    1, 0,  0, 2, 1, 1, 0, 0, 0, 800);

    odd_field = 1'b1;
    step("f_nf_run", 0, 0,    0, 1,  0, 2, 1, 1, 0, 0, 0, 800);
    step("f_fs_adv", 1, 900,  1, 0,  1, 3, 0, 1, 1, 0, 0, 850);
    step("f3",       0, 0,    1, 0,  1, 3, 1, 1, 0, 0, 0, 850);
    step("f4_odd",   1, 950,  1, 0,  2, 0, 0, 1, 0, 0, 0, 900);

    step("g_max",    1, 1600, 0, 0,  2, 0, 0, 0, 0, 0, 0, 900);
    step("g_nf",     0, 0,    0, 1,  0, 0, 0, 0, 0, 0, 0, 900);
    step("g_short",  1, 639,  0, 0,  0, 0, 0, 0, 0, 0, 0, 639);
    step("g_wait",   1, 1000, 0, 0,  0, 0, 0, 0, 0, 0, 0, 639);
    step("g_nf2",    0, 0,    0, 1,  0, 0, 0, 0, 0, 0, 0, 639);
    step("g_min",    1, 640,  0, 0,  1, 0, 0, 0, 0, 0, 0, 640);
    step("g_maxm1",  1, 1599, 0, 0,  2, 0, 0, 0, 0, 0, 0, 640);
    step("g_run",    0, 0,    0, 0,  2, 0, 0, 1, 1, 0, 0, 640);

    @(negedge VCLK); #1;
    nRST = 1'b0;
    #1;
    check_zero("h_async_rst");
    @(posedge VCLK); #1;
    nRST = 1'b1;
    step("h_idle",   0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    step("h_wait",   1, 1000, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    step("h_nf",     0, 0,    0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    step("h_wr",     1, 1000, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1000);
    enable = 1'b0;
    step("h_disable",0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 1000);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge VCLK);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
